aes_round_sequencer: RTL

//  Sequences one AES-128 encryption across the round-stage blocks: key expansion, sub-bytes, shift-rows,
//  mix-columns and add-round-key. It owns the 128-bit state register and the current round key.

---
 rtl/aes_round_sequencer.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/aes_round_sequencer.sv
// rtl/aes_round_sequencer.sv - AES-128 round/stage sequencer; optional stage timeout via AES_SEQ_TIMEOUT_EN
module aes_round_sequencer #(
    parameter int WORD_SIZE      = 8,
    parameter int ARRAY_SIZE     = 16,
    parameter int NUM_ROUNDS     = 10,
    parameter int TIMEOUT_CYCLES = 64,
    localparam int W             = WORD_SIZE * ARRAY_SIZE
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_i,
    input  logic [W-1:0] block_i,
    input  logic [W-1:0] key_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [W-1:0] block_o,
    output logic [3:0]   round_o,
    output logic         stage_clr_o,
    output logic [W-1:0] stage_state_o,
    output logic [W-1:0] round_key_o,
    output logic         kexp_en_o,
    input  logic         kexp_done_i,
    input  logic [W-1:0] kexp_key_i,
    output logic         sb_en_o,
    input  logic         sb_done_i,
    input  logic [W-1:0] sb_state_i,
    output logic         sr_en_o,
    input  logic         sr_done_i,
    input  logic [W-1:0] sr_state_i,
    output logic         mc_en_o,
    input  logic         mc_done_i,
    input  logic [W-1:0] mc_state_i,
    output logic         ark_en_o,
    input  logic         ark_done_i,
    input  logic [W-1:0] ark_state_i,
    output logic         err_o
);

    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

    // NEXT is not a registered state: the decision is taken on the RUN exit edge.
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_CLR, S_RUN, S_DONE, S_ERR
    } fsm_t;

    typedef enum logic [2:0] {
        ST_KEXP, ST_SB, ST_SR, ST_MC, ST_ARK
    } stage_t;

    fsm_t         fsm_q, fsm_d;
    logic [3:0]   round_q, round_d;
    logic [2:0]   stage_idx_q, stage_idx_d;
    logic [W-1:0] state_q, state_d;
    logic [W-1:0] rkey_q, rkey_d;
    stage_t       cur_stage;
    logic         sel_done;
    logic [W-1:0] sel_result;
    logic         run_en;

`ifdef AES_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_q, tmo_d;
`endif

    // Map (round, position in round) to the stage being run; ARK always closes a round.
    always_comb begin
        cur_stage = ST_ARK;
        if (round_q == 4'd0) begin
            cur_stage = (stage_idx_q == 3'd0) ? ST_KEXP : ST_ARK;
        end else begin
            case (stage_idx_q)
                3'd0:    cur_stage = ST_KEXP;
                3'd1:    cur_stage = ST_SB;
                3'd2:    cur_stage = ST_SR;
                3'd3:    cur_stage = (round_q == LAST_ROUND) ? ST_ARK : ST_MC;
                default: cur_stage = ST_ARK;
            endcase
        end
    end

    // Select the done flag and result of the stage currently being run.
    always_comb begin
        sel_done   = 1'b0;
        sel_result = '0;
        case (cur_stage)
            ST_KEXP: begin sel_done = kexp_done_i; sel_result = kexp_key_i;  end
            ST_SB:   begin sel_done = sb_done_i;   sel_result = sb_state_i;  end
            ST_SR:   begin sel_done = sr_done_i;   sel_result = sr_state_i;  end
            ST_MC:   begin sel_done = mc_done_i;   sel_result = mc_state_i;  end
            default: begin sel_done = ark_done_i;  sel_result = ark_state_i; end
        endcase
    end

    // Next-state logic: load, per-stage clear/run, result capture and round advance.
    always_comb begin
        fsm_d       = fsm_q;
        round_d     = round_q;
        stage_idx_d = stage_idx_q;
        state_d     = state_q;
        rkey_d      = rkey_q;
`ifdef AES_SEQ_TIMEOUT_EN
        tmo_d       = tmo_q;
`endif
        case (fsm_q)
            S_IDLE: begin
                if (start_i) begin
                    fsm_d       = S_LOAD;
                    state_d     = block_i;
                    // Round 0 key expansion reads the cipher key back from round_key_o.
                    rkey_d      = key_i;
                    round_d     = 4'd0;
                    stage_idx_d = 3'd0;
                end
            end
            S_LOAD: fsm_d = S_CLR;
            S_CLR: begin
                fsm_d = S_RUN;
`ifdef AES_SEQ_TIMEOUT_EN
                tmo_d = '0;
`endif
            end
            S_RUN: begin
                if (sel_done) begin
                    if (cur_stage == ST_KEXP) begin
                        rkey_d = sel_result;
                    end else begin
                        state_d = sel_result;
                    end
                    if (cur_stage != ST_ARK) begin
                        stage_idx_d = stage_idx_q + 3'd1;
                        fsm_d       = S_CLR;
                    end else if (round_q == LAST_ROUND) begin
                        fsm_d = S_DONE;
                    end else begin
                        round_d     = round_q + 4'd1;
                        stage_idx_d = 3'd0;
                        fsm_d       = S_CLR;
                    end
                end
`ifdef AES_SEQ_TIMEOUT_EN
                else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    fsm_d = S_ERR;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
`endif
            end
            S_DONE:  fsm_d = S_IDLE;
            S_ERR:   fsm_d = S_ERR;
            default: fsm_d = S_IDLE;
        endcase
    end

    // State, round, stage position and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q       <= S_IDLE;
            round_q     <= 4'd0;
            stage_idx_q <= 3'd0;
            state_q     <= '0;
            rkey_q      <= '0;
        end else begin
            fsm_q       <= fsm_d;
            round_q     <= round_d;
            stage_idx_q <= stage_idx_d;
            state_q     <= state_d;
            rkey_q      <= rkey_d;
        end
    end

`ifdef AES_SEQ_TIMEOUT_EN
    // Per-stage RUN cycle counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
    assign err_o = (fsm_q == S_ERR);
`else
    assign err_o = 1'b0;
`endif

    // Enables are gated by rst so they fall in the same cycle reset is raised.
    assign run_en        = (fsm_q == S_RUN) && !rst;
    assign kexp_en_o     = run_en && (cur_stage == ST_KEXP);
    assign sb_en_o       = run_en && (cur_stage == ST_SB);
    assign sr_en_o       = run_en && (cur_stage == ST_SR);
    assign mc_en_o       = run_en && (cur_stage == ST_MC);
    assign ark_en_o      = run_en && (cur_stage == ST_ARK);
    assign stage_clr_o   = (fsm_q == S_CLR);
    assign busy_o        = (fsm_q == S_LOAD) || (fsm_q == S_CLR) || (fsm_q == S_RUN);
    assign done_o        = (fsm_q == S_DONE);
    assign round_o       = round_q;
    assign block_o       = state_q;
    assign stage_state_o = state_q;
    assign round_key_o   = rkey_q;

endmodule
